// File: rtl/hydra_pkg.sv
// Shared definitions for the packet-buffer read path: page geometry, address
// field widths and the read-controller state encoding.
package hydra_pkg;

  localparam int PAGE_WORDS  = 8;
  localparam int SRAM_IDX_W  = 5;
  localparam int PAGE_ADDR_W = 11;
  localparam int PORT_W      = 4;
  localparam int HEAD_W      = SRAM_IDX_W + PAGE_ADDR_W;
  localparam int WORD_W      = 16;
  localparam int WORD_CNT_W  = $clog2(PAGE_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    REQ    = 2'd2,
    WAIT   = 2'd3
  } rd_ctrl_state_t;

  typedef struct packed {
    logic              eop;
    logic [WORD_W-1:0] data;
  } out_word_t;

  // Upper field of a head address selects the SRAM bank holding the packet.
  function automatic logic [SRAM_IDX_W-1:0] head_sram_idx(input logic [HEAD_W-1:0] head);
    return head[HEAD_W-1 -: SRAM_IDX_W];
  endfunction

endpackage

// File: rtl/port_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count. A push on a
// full FIFO is taken only when a pop happens in the same cycle.
module port_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset: contents are only observable through count/empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/port_rd_ctrl.sv
// Egress read initiator for one output port: queues packet heads, requests
// page reads from the SRAM side under buffer credit, and streams words out.
module port_rd_ctrl
  import hydra_pkg::*;
#(
  parameter int PORT_IDX    = 0,
  parameter int QUEUE_DEPTH = 32,
  parameter int BUF_DEPTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enq_vld,
  input  logic [HEAD_W-1:0]     enq_head_addr,
  output logic                  enq_rdy,
  output logic [8:0]            pkt_count,
  output logic                  rd_next,
  output logic [PORT_W-1:0]     rd_port,
  output logic [SRAM_IDX_W-1:0] rd_sram_sel,
  output logic [HEAD_W-1:0]     rd_packet_head_addr,
  input  logic                  rd_grant,
  input  logic                  rd_xfer_data_vld,
  input  logic [PORT_W-1:0]     rd_xfer_port,
  input  logic [WORD_W-1:0]     rd_xfer_data,
  input  logic                  rd_end_of_packet,
  output logic                  out_vld,
  output logic [WORD_W-1:0]     out_data,
  output logic                  out_eop,
  input  logic                  out_rdy,
  output logic                  err_ovf,
  output rd_ctrl_state_t        dbg_state
);

  localparam int QCW = $clog2(QUEUE_DEPTH) + 1;
  localparam int BCW = $clog2(BUF_DEPTH) + 1;
  // A page may be requested only while a whole page of space is free.
  localparam logic [BCW-1:0] CREDIT_LIMIT = BCW'(BUF_DEPTH - PAGE_WORDS);
  localparam logic [WORD_CNT_W-1:0] LAST_WORD = WORD_CNT_W'(PAGE_WORDS - 1);

  rd_ctrl_state_t        state;
  rd_ctrl_state_t        state_nxt;
  logic [WORD_CNT_W-1:0] word_cnt;

  logic              q_push;
  logic              q_pop;
  logic [HEAD_W-1:0] q_head;
  logic              q_full;
  logic              q_empty;
  logic [QCW-1:0]    q_count;

  logic              b_push;
  logic              b_pop;
  out_word_t         b_wdata;
  out_word_t         b_rdata;
  logic              b_full;
  logic              b_empty;
  logic [BCW-1:0]    b_count;

  logic              word_accept;
  logic              page_done;
  logic              credit_ok;
  logic              buf_drop;

  // ---------------------------------------------------------------- head queue
  assign enq_rdy = ~q_full;
  assign q_push  = enq_vld & ~q_full;

  port_fifo #(
    .WIDTH (HEAD_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_head_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .wdata (enq_head_addr),
    .pop   (q_pop),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // The in-service packet stays in the queue until its eop word arrives, so
  // the queue occupancy is exactly the queued-plus-in-service packet count.
  assign pkt_count           = 9'(q_count);
  assign rd_packet_head_addr = q_empty ? '0 : q_head;
  assign rd_sram_sel         = head_sram_idx(rd_packet_head_addr);
  assign rd_port             = PORT_W'(PORT_IDX);

  // ------------------------------------------------------------ output buffer
  // Handshake: a word transfers on the cycle out_vld & out_rdy are both high;
  // out_data/out_eop hold while out_vld is high and out_rdy is low.
  assign b_push       = word_accept;
  assign b_wdata.eop  = rd_end_of_packet;
  assign b_wdata.data = rd_xfer_data;
  assign b_pop        = out_vld & out_rdy;

  port_fifo #(
    .WIDTH ($bits(out_word_t)),
    .DEPTH (BUF_DEPTH)
  ) u_out_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (b_push),
    .wdata (b_wdata),
    .pop   (b_pop),
    .rdata (b_rdata),
    .full  (b_full),
    .empty (b_empty),
    .count (b_count)
  );

  assign out_vld   = ~b_empty;
  assign out_data  = b_rdata.data;
  assign out_eop   = b_rdata.eop;
  assign credit_ok = (b_count <= CREDIT_LIMIT);
  assign buf_drop  = word_accept & b_full & ~b_pop;

  // ---------------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!q_empty) state_nxt = CREDIT;
      CREDIT: if (credit_ok) state_nxt = REQ;
      REQ:    if (rd_grant) state_nxt = WAIT;
      WAIT: begin
        if (word_accept && rd_end_of_packet) state_nxt = IDLE;
        else if (page_done)                  state_nxt = CREDIT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_next     = (state == REQ);
    word_accept = rd_xfer_data_vld & (rd_xfer_port == PORT_W'(PORT_IDX)) & (state == WAIT);
    q_pop       = word_accept & rd_end_of_packet;
    page_done   = word_accept & ~rd_end_of_packet & (word_cnt == LAST_WORD);
  end

  assign dbg_state = state;

  // Words returned within the current page; wraps to 0 at the page boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
    end else if (state == REQ && rd_grant) begin
      word_cnt <= '0;
    end else if (word_accept) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_ovf <= 1'b0;
    else if ((enq_vld && q_full) || buf_drop) err_ovf <= 1'b1;
  end

  // The credit check makes a dropped word impossible.
  a_no_buf_drop: assert property (@(posedge clk) disable iff (!rst_n) !buf_drop);

endmodule

// File: tb/tb_port_rd_ctrl.sv
// Bench for port_rd_ctrl: an SRAM-side responder serves page reads from a
// table of packets; the expected word stream is built from the packet table.
module tb_port_rd_ctrl;
  import hydra_pkg::*;

  localparam int PORT_IDX = 3;
  localparam int QD       = 32;
  localparam int BD       = 32;
  localparam logic [3:0] MY_PORT = 4'(PORT_IDX);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enq_vld = 1'b0;
  logic [15:0] enq_head_addr = '0;
  logic        enq_rdy;
  logic [8:0]  pkt_count;
  logic        rd_next;
  logic [3:0]  rd_port;
  logic [4:0]  rd_sram_sel;
  logic [15:0] rd_packet_head_addr;
  logic        rd_grant = 1'b0;
  logic        rd_xfer_data_vld = 1'b0;
  logic [3:0]  rd_xfer_port = '0;
  logic [15:0] rd_xfer_data = '0;
  logic        rd_end_of_packet = 1'b0;
  logic        out_vld;
  logic [15:0] out_data;
  logic        out_eop;
  logic        out_rdy = 1'b1;
  logic        err_ovf;
  rd_ctrl_state_t dbg_state;

  port_rd_ctrl #(
    .PORT_IDX    (PORT_IDX),
    .QUEUE_DEPTH (QD),
    .BUF_DEPTH   (BD)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .enq_vld             (enq_vld),
    .enq_head_addr       (enq_head_addr),
    .enq_rdy             (enq_rdy),
    .pkt_count           (pkt_count),
    .rd_next             (rd_next),
    .rd_port             (rd_port),
    .rd_sram_sel         (rd_sram_sel),
    .rd_packet_head_addr (rd_packet_head_addr),
    .rd_grant            (rd_grant),
    .rd_xfer_data_vld    (rd_xfer_data_vld),
    .rd_xfer_port        (rd_xfer_port),
    .rd_xfer_data        (rd_xfer_data),
    .rd_end_of_packet    (rd_end_of_packet),
    .out_vld             (out_vld),
    .out_data            (out_data),
    .out_eop             (out_eop),
    .out_rdy             (out_rdy),
    .err_ovf             (err_ovf),
    .dbg_state           (dbg_state)
  );

  // ------------------------------------------------------- clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- state
  int n_checks = 0;
  int n_pass   = 0;

  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];
  int          vld_seen = 0;

  int          pkt_len [logic [15:0]];
  int          sent    [logic [15:0]];
  logic [10:0] page_ctr = 11'd16;

  bit          r_busy = 1'b0;
  int          r_left = 0;
  logic [15:0] r_addr = '0;
  bit          resp_hold = 1'b0;
  bit          foreign_en = 1'b0;
  int          grant_cnt = 0;
  int          req_while_busy = 0;
  int          rdy_mode = 0;

  function automatic logic [15:0] word_val(input logic [15:0] a, input int i);
    return (a * 16'd37) ^ 16'(i * 613 + 32'h1234);
  endfunction

  // ------------------------------------------------- SRAM-side responder
  initial begin : responder
    int idx;
    forever begin
      @(posedge clk); #1;
      rd_grant         = 1'b0;
      rd_xfer_data_vld = 1'b0;
      rd_end_of_packet = 1'b0;
      rd_xfer_port     = MY_PORT;
      rd_xfer_data     = '0;
      if (r_busy && rd_next) req_while_busy++;
      if (!r_busy) begin
        if (rd_next && !resp_hold && $urandom_range(0, 1) == 0) begin
          rd_grant = 1'b1;
          r_addr   = rd_packet_head_addr;
          r_busy   = 1'b1;
          grant_cnt++;
          r_left = pkt_len[r_addr] - sent[r_addr];
          if (r_left > PAGE_WORDS) r_left = PAGE_WORDS;
        end
      end else if (foreign_en && $urandom_range(0, 3) == 0) begin
        rd_xfer_data_vld = 1'b1;
        rd_xfer_port     = MY_PORT + 4'd1;
        rd_xfer_data     = 16'($urandom);
        rd_end_of_packet = 1'($urandom_range(0, 1));
      end else if ($urandom_range(0, 3) != 0) begin
        idx              = sent[r_addr];
        rd_xfer_data_vld = 1'b1;
        rd_xfer_data     = word_val(r_addr, idx);
        rd_end_of_packet = (idx == pkt_len[r_addr] - 1);
        sent[r_addr]     = idx + 1;
        r_left--;
        if (r_left == 0) r_busy = 1'b0;
      end
    end
  end

  // ------------------------------------------------------ out_rdy driver
  initial begin : rdy_driver
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = 1'b0;
        default: out_rdy = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // ------------------------------------------------------------- monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_vld) vld_seen++;
      if (out_vld && out_rdy) got_q.push_back({out_eop, out_data});
    end
  end

  // ------------------------------------------------------- driver tasks
  task automatic new_addr(output logic [15:0] a);
    a = {5'($urandom_range(0, 31)), page_ctr};
    page_ctr++;
  endtask

  task automatic enq_pkt(input logic [15:0] a, input int len);
    pkt_len[a] = len;
    sent[a]    = 0;
    for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), word_val(a, i)});
    enq_vld       = 1'b1;
    enq_head_addr = a;
    @(posedge clk); #1;
    enq_vld = 1'b0;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (got_q.size() == exp_q.size() && pkt_count == 9'd0 && !r_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    grant_cnt      = 0;
    req_while_busy = 0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({out_vld, rd_next} !== 2'b00) $display("FAIL reset_hold_outputs: got %b expected 00", {out_vld, rd_next});
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({enq_rdy, out_vld, rd_next, err_ovf} !== 4'b1000)
      $display("FAIL reset_flags: got %b expected 1000", {enq_rdy, out_vld, rd_next, err_ovf});
    else n_pass++;
    n_checks++;
    if (pkt_count !== 9'd0) $display("FAIL reset_pkt_count: got %0d expected 0", pkt_count);
    else n_pass++;
    n_checks++;
    if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    else n_pass++;
    n_checks++;
    if (rd_port !== MY_PORT) $display("FAIL rd_port: got %0d expected %0d", rd_port, MY_PORT);
    else n_pass++;
  endtask

  task automatic test_single();
    bit seen;
    bit ok;
    clear_sb();
    rdy_mode = 0;
    enq_pkt(16'h0803, 5);
    n_checks++;
    if (pkt_count !== 9'd1) $display("FAIL single_pkt_count_up: got %0d expected 1", pkt_count);
    else n_pass++;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      seen = rd_next;
    end
    n_checks++;
    if (!seen) $display("FAIL single_req: got no rd_next expected rd_next within 20 cycles");
    else if ({rd_sram_sel, rd_packet_head_addr} !== {5'd1, 16'h0803})
      $display("FAIL single_req_addr: got sel %0d addr %h expected sel 1 addr 0803", rd_sram_sel, rd_packet_head_addr);
    else n_pass++;
    wait_drain(300, ok);
    n_checks++;
    if (!ok || got_q.size() != exp_q.size())
      $display("FAIL single_words: got %0d words expected %0d (drained %0d)", got_q.size(), exp_q.size(), ok);
    else n_pass++;
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL single_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (pkt_count !== 9'd0 || grant_cnt != 1)
      $display("FAIL single_end: got pkt_count %0d grants %0d expected 0 and 1", pkt_count, grant_cnt);
    else n_pass++;
  endtask

  task automatic test_multi_page();
    logic [15:0] a;
    bit ok;
    clear_sb();
    rdy_mode = 0;
    new_addr(a);
    enq_pkt(a, 20);
    wait_drain(600, ok);
    n_checks++;
    if (!ok || got_q.size() != exp_q.size())
      $display("FAIL multi_words: got %0d words expected %0d (drained %0d)", got_q.size(), exp_q.size(), ok);
    else n_pass++;
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL multi_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (grant_cnt != 3 || req_while_busy != 0)
      $display("FAIL multi_grants: got grants %0d early_reqs %0d expected 3 and 0", grant_cnt, req_while_busy);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [15:0] a;
    bit ok;
    clear_sb();
    rdy_mode = 1;
    @(posedge clk); #1;
    new_addr(a);
    enq_pkt(a, 40);
    repeat (250) @(posedge clk);
    #1;
    // 32-entry buffer, 8-word pages: four pages fit, the fifth must wait.
    n_checks++;
    if (grant_cnt != 4 || got_q.size() != 0)
      $display("FAIL bp_stall: got grants %0d out_words %0d expected 4 and 0", grant_cnt, got_q.size());
    else n_pass++;
    n_checks++;
    if ({out_vld, err_ovf} !== 2'b10 || dbg_state !== CREDIT)
      $display("FAIL bp_state: got vld/ovf %b state %0d expected 10 state %0d", {out_vld, err_ovf}, dbg_state, CREDIT);
    else n_pass++;
    rdy_mode = 0;
    wait_drain(600, ok);
    n_checks++;
    if (!ok || got_q.size() != exp_q.size())
      $display("FAIL bp_words: got %0d words expected %0d (drained %0d)", got_q.size(), exp_q.size(), ok);
    else n_pass++;
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL bp_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (grant_cnt != 5 || err_ovf !== 1'b0)
      $display("FAIL bp_resume: got grants %0d err_ovf %b expected 5 and 0", grant_cnt, err_ovf);
    else n_pass++;
  endtask

  task automatic test_foreign();
    logic [15:0] a;
    logic [15:0] b;
    bit ok;
    clear_sb();
    rdy_mode   = 0;
    foreign_en = 1'b1;
    new_addr(a);
    new_addr(b);
    enq_pkt(a, 12);
    enq_pkt(b, 3);
    wait_drain(800, ok);
    foreign_en = 1'b0;
    n_checks++;
    if (!ok || got_q.size() != exp_q.size())
      $display("FAIL foreign_words: got %0d words expected %0d (drained %0d)", got_q.size(), exp_q.size(), ok);
    else n_pass++;
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL foreign_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    int len;
    int exp_grants;
    bit ok;
    clear_sb();
    rdy_mode   = 2;
    foreign_en = 1'($urandom_range(0, 1));
    exp_grants = 0;
    for (int p = 0; p < 5; p++) begin
      new_addr(a);
      len = int'($urandom_range(1, 24));
      exp_grants += (len + PAGE_WORDS - 1) / PAGE_WORDS;
      enq_pkt(a, len);
    end
    wait_drain(3000, ok);
    foreign_en = 1'b0;
    rdy_mode   = 0;
    n_checks++;
    if (!ok || got_q.size() != exp_q.size())
      $display("FAIL rand_words: got %0d words expected %0d (drained %0d)", got_q.size(), exp_q.size(), ok);
    else n_pass++;
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL rand_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (grant_cnt != exp_grants || req_while_busy != 0 || err_ovf !== 1'b0)
      $display("FAIL rand_grants: got grants %0d early_reqs %0d ovf %b expected %0d 0 0",
               grant_cnt, req_while_busy, err_ovf, exp_grants);
    else n_pass++;
  endtask

  task automatic test_queue_full();
    logic [15:0] a;
    clear_sb();
    resp_hold = 1'b1;
    for (int p = 0; p < QD; p++) begin
      new_addr(a);
      enq_pkt(a, 1);
    end
    n_checks++;
    if ({enq_rdy, err_ovf} !== 2'b00 || pkt_count !== 9'd32)
      $display("FAIL qfull_state: got rdy/ovf %b pkt_count %0d expected 00 and 32", {enq_rdy, err_ovf}, pkt_count);
    else n_pass++;
    new_addr(a);
    enq_pkt(a, 1);
    n_checks++;
    if (err_ovf !== 1'b1 || pkt_count !== 9'd32)
      $display("FAIL qfull_overflow: got err_ovf %b pkt_count %0d expected 1 and 32", err_ovf, pkt_count);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [15:0] a;
    bit reached;
    int v0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    resp_hold = 1'b0;
    rdy_mode  = 0;
    clear_sb();
    new_addr(a);
    enq_pkt(a, 20);
    reached = 1'b0;
    for (int c = 0; c < 300 && !reached; c++) begin
      @(posedge clk); #1;
      reached = (dbg_state == WAIT) && r_busy && (got_q.size() >= 2);
    end
    n_checks++;
    if (!reached) $display("FAIL rstmid_reach: got no mid-page point expected WAIT with words flowing");
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({enq_rdy, out_vld, rd_next, err_ovf} !== 4'b1000 || pkt_count !== 9'd0)
      $display("FAIL rstmid_outputs: got %b pkt_count %0d expected 1000 and 0",
               {enq_rdy, out_vld, rd_next, err_ovf}, pkt_count);
    else n_pass++;
    n_checks++;
    if (dbg_state !== IDLE) $display("FAIL rstmid_state: got %0d expected %0d", dbg_state, IDLE);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    v0 = vld_seen;
    repeat (40) @(posedge clk);
    #1;
    n_checks++;
    if (vld_seen != v0 || out_vld !== 1'b0 || rd_next !== 1'b0)
      $display("FAIL rstmid_late_words: got %0d out_vld cycles rd_next %b expected 0 and 0", vld_seen - v0, rd_next);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    test_reset();
    test_single();
    test_multi_page();
    test_backpressure();
    test_foreign();
    test_random();
    test_queue_full();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
